// File: rtl/a2d_rr_sweep_pkg.sv
// ----------------------------------------------------------------------------
// a2d_pkg
//   Shared types and constants for the a2d_rr_sweep front end.
//   - state_t    : sequencer states IDLE / CMD / GAP / READ
//   - A2D_ADDR_W : width of an A2D channel address
//   - A2D_CMD_W  : width of one SPI frame
//   - build_cmd  : forms the 16-bit conversion command for an address
// ----------------------------------------------------------------------------
package a2d_pkg;

    localparam int A2D_ADDR_W = 3;
    localparam int A2D_CMD_W  = 16;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        GAP,
        READ
    } state_t;

    // Command frame: two zero bits, the channel address, then 11 don't-care
    // zeros while the A2D shifts back the previous conversion.
    function automatic logic [A2D_CMD_W-1:0] build_cmd(input logic [A2D_ADDR_W-1:0] addr);
        return {2'b00, addr, 11'h000};
    endfunction

endpackage

// File: rtl/a2d_rr_sweep_if.sv
// ----------------------------------------------------------------------------
// a2d_rr_sweep_if
//   Request / result bundle between the control logic and a2d_rr_sweep.
//   nxt, burst         : conversion request and its mode (requester drives)
//   ch_data            : latest result per channel, ch k at [k*DATA_W +: DATA_W]
//   ch_vld             : 1-cycle update strobe per channel
//   sweep_done, busy   : request completion pulse and in-progress flag
//   modport master : requester side;  modport slave : the converter.
// ----------------------------------------------------------------------------
interface a2d_rr_sweep_if
    import a2d_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 12
) ();

    logic                       nxt;
    logic                       burst;
    logic [NUM_CH*DATA_W-1:0]   ch_data;
    logic [NUM_CH-1:0]          ch_vld;
    logic                       sweep_done;
    logic                       busy;

    modport master (
        output nxt, burst,
        input  ch_data, ch_vld, sweep_done, busy
    );

    modport slave (
        input  nxt, burst,
        output ch_data, ch_vld, sweep_done, busy
    );

endinterface

// File: rtl/a2d_rr_sweep_spi_mnrch.sv
// ----------------------------------------------------------------------------
// SPI_mnrch
//   16-bit SPI master, SCLK = clk/32, idle-high clock. The slave is sampled
//   just before each SCLK rise and data advances on each SCLK fall after the
//   first rise, so 16 rises move one full frame in each direction.
//   clk, rst_n        : system clock, async active-low reset
//   wrt, wt_data      : start a frame with this transmit word (ignored if busy)
//   done, rd_data     : 1-cycle pulse with the received word valid alongside
//   SS_n, SCLK, MOSI  : SPI outputs;  MISO : SPI input
// ----------------------------------------------------------------------------
module SPI_mnrch
    import a2d_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wrt,
    input  logic [A2D_CMD_W-1:0] wt_data,
    output logic                 done,
    output logic [A2D_CMD_W-1:0] rd_data,
    output logic                 SS_n,
    output logic                 SCLK,
    output logic                 MOSI,
    input  logic                 MISO
);

    // Divider parked at 10111 while idle keeps SCLK high and gives a short
    // front porch before the first falling edge.
    localparam logic [4:0] DIV_IDLE = 5'b10111;
    localparam logic [4:0] DIV_RISE = 5'b01111;
    localparam logic [4:0] DIV_FALL = 5'b11111;

    logic                 active;
    logic [4:0]           div;
    logic [4:0]           bit_cnt;
    logic [A2D_CMD_W-1:0] shft;
    logic                 miso_smpl;

    // NOTE: sequential state uses non-blocking assignments so every flop sees
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active    <= 1'b0;
            div       <= DIV_IDLE;
            bit_cnt   <= '0;
            shft      <= '0;
            miso_smpl <= 1'b0;
            done      <= 1'b0;
            SS_n      <= 1'b1;
        end else begin
            done <= 1'b0;
            if (!active) begin
                if (wrt) begin
                    active  <= 1'b1;
                    SS_n    <= 1'b0;
                    shft    <= wt_data;
                    bit_cnt <= '0;
                end
            end else begin
                div <= div + 5'd1;
                // MISO comes from a slave clocked by our own SCLK, so it is
                // already synchronous to clk by the time it is sampled here.
                if (div == DIV_RISE) begin
                    miso_smpl <= MISO;
                    bit_cnt   <= bit_cnt + 5'd1;
                end
                // The first falling edge precedes any sample and shifts nothing.
                if (div == DIV_FALL && bit_cnt != 5'd0) begin
                    shft <= {shft[A2D_CMD_W-2:0], miso_smpl};
                    if (bit_cnt == 5'd16) begin
                        active <= 1'b0;
                        SS_n   <= 1'b1;
                        div    <= DIV_IDLE;
                        done   <= 1'b1;
                    end
                end
            end
        end
    end

    assign SCLK    = div[4];
    assign MOSI    = shft[A2D_CMD_W-1];
    assign rd_data = shft;

endmodule

// File: rtl/a2d_rr_sweep.sv
// ----------------------------------------------------------------------------
// a2d_rr_sweep
//   Multi-channel A2D front end over one SPI_mnrch. A single request converts
//   the round-robin channel (2 frames); a burst request sweeps all channels
//   pipelined (NUM_CH+1 frames, each frame returns the previous channel).
//   clk, rst_n        : system clock, async active-low reset
//   bus (slave)       : nxt/burst request, ch_data/ch_vld results,
//                       sweep_done completion pulse, busy
//   SS_n, SCLK, MOSI  : SPI outputs;  MISO : SPI input
//   Build option A2D_AVG_EN: each capture becomes a first-order IIR update
//   ch += (sample - ch) >>> AVG_SH; the first capture after reset seeds it.
// ----------------------------------------------------------------------------
module a2d_rr_sweep
    import a2d_pkg::*;
#(
    parameter int                     NUM_CH  = 4,
    parameter int                     DATA_W  = 12,
    parameter logic [3*NUM_CH-1:0]    CH_ADDR = {3'd6, 3'd5, 3'd4, 3'd0},
    parameter int                     AVG_SH  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    a2d_rr_sweep_if.slave   bus,
    output logic            SS_n,
    output logic            SCLK,
    output logic            MOSI,
    input  logic            MISO
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TXN_W = $clog2(NUM_CH + 1);
    localparam logic [PTR_W-1:0] LAST_CH  = PTR_W'(NUM_CH - 1);
    localparam logic [TXN_W-1:0] LAST_TXN = TXN_W'(NUM_CH);

    state_t               state, nxt_state;
    logic [PTR_W-1:0]     rr;
    logic [TXN_W-1:0]     txn;      // index of the frame in flight (burst)
    logic [PTR_W-1:0]     txn_lo;
    logic                 burst_q;

    logic                 wrt;
    logic [A2D_CMD_W-1:0] wt_data;
    logic                 done;
    logic [A2D_CMD_W-1:0] rd_data;

    logic                 cap_en;
    logic                 final_cap;
    logic [PTR_W-1:0]     cap_idx;
    logic [DATA_W-1:0]    sample;
    logic [DATA_W-1:0]    new_val;
    logic                 unused_rd;

    logic [DATA_W-1:0]        ch_q [NUM_CH];
    logic [NUM_CH-1:0]        vld_q;
    logic                     sweep_done_q;
    logic [NUM_CH*DATA_W-1:0] ch_flat;

    logic [A2D_ADDR_W-1:0]    addr_tbl [NUM_CH];

    for (genvar k = 0; k < NUM_CH; k++) begin : g_addr
        assign addr_tbl[k] = CH_ADDR[A2D_ADDR_W*k +: A2D_ADDR_W];
    end

    assign txn_lo    = txn[PTR_W-1:0];
    assign sample    = rd_data[DATA_W-1:0];
    assign unused_rd = ^(rd_data >> DATA_W);

    SPI_mnrch u_spi (
        .clk     (clk),
        .rst_n   (rst_n),
        .wrt     (wrt),
        .wt_data (wt_data),
        .done    (done),
        .rd_data (rd_data),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO)
    );

    // ---------------- sequencer ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rr      <= '0;
            txn     <= '0;
            burst_q <= 1'b0;
        end else begin
            state <= nxt_state;
            if (state == IDLE && bus.nxt) begin
                burst_q <= bus.burst;
                txn     <= '0;
            end else if (state == GAP) begin
                txn <= txn + 1'b1;
            end
            // Burst sweeps never move the round-robin pointer.
            if (final_cap && !burst_q)
                rr <= (rr == LAST_CH) ? '0 : rr + 1'b1;
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no branch
        // can leave one unassigned and infer a latch.
        nxt_state = state;
        wrt       = 1'b0;
        wt_data   = '0;
        cap_en    = 1'b0;
        final_cap = 1'b0;
        cap_idx   = rr;
        unique case (state)
            IDLE: begin
                if (bus.nxt) begin
                    wrt       = 1'b1;
                    wt_data   = build_cmd(bus.burst ? addr_tbl[0] : addr_tbl[rr]);
                    nxt_state = CMD;
                end
            end
            CMD: begin
                if (done)
                    nxt_state = GAP;
            end
            GAP: begin
                // Single mode repeats its address to clock the result back;
                // burst sends the next channel, with ch0 as the closing dummy.
                wrt       = 1'b1;
                nxt_state = READ;
                if (!burst_q)
                    wt_data = build_cmd(addr_tbl[rr]);
                else if (txn == LAST_TXN - 1'b1)
                    wt_data = build_cmd(addr_tbl[0]);
                else
                    wt_data = build_cmd(addr_tbl[txn_lo + 1'b1]);
            end
            READ: begin
                if (done) begin
                    cap_en = 1'b1;
                    if (burst_q) begin
                        cap_idx = txn_lo - 1'b1;
                        if (txn < LAST_TXN)
                            nxt_state = GAP;
                        else
                            final_cap = 1'b1;
                    end else begin
                        final_cap = 1'b1;
                    end
                    if (final_cap)
                        nxt_state = IDLE;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    // ---------------- capture ----------------
`ifdef A2D_AVG_EN
    logic [NUM_CH-1:0]      seeded;
    logic signed [DATA_W:0] diff;

    always_comb begin
        diff    = $signed({1'b0, sample}) - $signed({1'b0, ch_q[cap_idx]});
        new_val = seeded[cap_idx] ? ch_q[cap_idx] + DATA_W'(diff >>> AVG_SH) : sample;
    end
`else
    localparam int unused_avg_sh = AVG_SH;  // AVG_SH is used only when averaging is built in
    assign new_val = sample;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the result array is reset on purpose: a reset must clear
            // every published channel value, not just the control state.
            for (int k = 0; k < NUM_CH; k++)
                ch_q[k] <= '0;
            vld_q        <= '0;
            sweep_done_q <= 1'b0;
`ifdef A2D_AVG_EN
            seeded       <= '0;
`endif
        end else begin
            vld_q        <= '0;
            sweep_done_q <= final_cap;
            if (cap_en) begin
                ch_q[cap_idx]  <= new_val;
                vld_q[cap_idx] <= 1'b1;
`ifdef A2D_AVG_EN
                seeded[cap_idx] <= 1'b1;
`endif
            end
        end
    end

    always_comb begin
        ch_flat = '0;
        for (int k = 0; k < NUM_CH; k++)
            ch_flat[k*DATA_W +: DATA_W] = ch_q[k];
    end

    assign bus.ch_data    = ch_flat;
    assign bus.ch_vld     = vld_q;
    assign bus.sweep_done = sweep_done_q;
    assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_a2d_rr_sweep.sv
// ----------------------------------------------------------------------------
// tb_a2d_rr_sweep
//   Directed bench for a2d_rr_sweep with an A2D SPI slave model. Each frame
//   returns the value of the channel addressed in the previous frame:
//   addr 0/4/5/6 -> 12'h100/101/102/103.
// ----------------------------------------------------------------------------
module tb_a2d_rr_sweep;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 12;
    localparam int BUDGET = 6000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic SS_n, SCLK, MOSI, MISO;

    a2d_rr_sweep_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

    a2d_rr_sweep #(
        .NUM_CH  (NUM_CH),
        .DATA_W  (DATA_W),
        .CH_ADDR ({3'd6, 3'd5, 3'd4, 3'd0}),
        .AVG_SH  (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .SS_n  (SS_n),
        .SCLK  (SCLK),
        .MOSI  (MOSI),
        .MISO  (MISO)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- A2D slave model ----------------
    logic [11:0] ch0_val = 12'h100;
    logic [15:0] s_tx    = '0;
    logic [15:0] s_rx    = '0;
    logic [2:0]  s_prev  = '0;
    bit          s_seen;
    int          frames  = 0;
    logic [2:0]  addr_log [$];

    function automatic logic [11:0] chan_val(input logic [2:0] a);
        case (a)
            3'd0:    return ch0_val;
            3'd4:    return 12'h101;
            3'd5:    return 12'h102;
            3'd6:    return 12'h103;
            default: return 12'hFFF;
        endcase
    endfunction

    assign MISO = s_tx[15];

    initial begin : a2d_slave
        forever begin
            @(negedge SS_n);
            s_tx   = {4'h0, chan_val(s_prev)};
            s_seen = 1'b0;
            while (SS_n === 1'b0) begin
                @(SCLK or SS_n);
                if (SS_n !== 1'b0) break;
                if (SCLK === 1'b1) begin
                    s_rx   = {s_rx[14:0], MOSI};
                    s_seen = 1'b1;
                end else if (s_seen) begin
                    s_tx = {s_tx[14:0], 1'b0};
                end
            end
            frames++;
            addr_log.push_back(s_rx[13:11]);
            s_prev = s_rx[13:11];
        end
    end

    // ---------------- output monitor ----------------
    logic [NUM_CH-1:0] vld_log [$];
    int                done_cnt = 0;

    always @(negedge clk) begin
        if (bus.ch_vld != '0) vld_log.push_back(bus.ch_vld);
        if (bus.sweep_done)   done_cnt++;
    end

    // ---------------- helpers ----------------
    int f0, v0, a0, d0;

    task automatic mark();
        f0 = frames;
        v0 = vld_log.size();
        a0 = addr_log.size();
        d0 = done_cnt;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pulse_nxt(input logic b);
        @(negedge clk);
        bus.nxt   = 1'b1;
        bus.burst = b;
        @(negedge clk);
        bus.nxt   = 1'b0;
        bus.burst = 1'b0;
    endtask

    // Returns just after the posedge that follows the sweep_done cycle.
    task automatic wait_sweep(input string tag);
        int n = 0;
        while (done_cnt == d0 && n < BUDGET) begin
            @(posedge clk);
            n++;
        end
        check({tag, "_no_timeout"}, 64'(done_cnt != d0), 64'd1);
    endtask

    task automatic run_req(input logic b, input string tag);
        mark();
        pulse_nxt(b);
        wait_sweep(tag);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic              burst;
        int                frames;
        int                vld_n;
        logic [NUM_CH-1:0] vld0;
        logic [2:0]        last_addr;
    } vec_t;

    vec_t vecs [7];

    initial begin
        bus.nxt   = 1'b0;
        bus.burst = 1'b0;

        vecs[0] = '{1'b0, 2, 1, 4'b0001, 3'd0};
        vecs[1] = '{1'b0, 2, 1, 4'b0010, 3'd4};
        vecs[2] = '{1'b0, 2, 1, 4'b0100, 3'd5};
        vecs[3] = '{1'b0, 2, 1, 4'b1000, 3'd6};
        vecs[4] = '{1'b0, 2, 1, 4'b0001, 3'd0};   // rr wraps to ch0
        vecs[5] = '{1'b1, 5, 4, 4'b0001, 3'd0};   // burst ends with dummy addr 0
        vecs[6] = '{1'b0, 2, 1, 4'b0010, 3'd4};   // rr survives the burst: ch1

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("rst_ch_data",    64'(bus.ch_data), 64'd0);
        check("rst_ch_vld",     64'(bus.ch_vld),  64'd0);
        check("rst_sweep_done", 64'(bus.sweep_done), 64'd0);
        check("rst_busy",       64'(bus.busy), 64'd0);
        check("rst_ss_n",       64'(SS_n), 64'd1);
        check("rst_sclk",       64'(SCLK), 64'd1);
        rst_n = 1'b1;

        // ---- table-driven requests ----
        for (int i = 0; i < 7; i++) begin
            run_req(vecs[i].burst, $sformatf("v%0d", i));
            check($sformatf("v%0d_frames", i),    64'(frames - f0), 64'(vecs[i].frames));
            check($sformatf("v%0d_vld_n", i),     64'(vld_log.size() - v0), 64'(vecs[i].vld_n));
            check($sformatf("v%0d_vld0", i),      64'(vld_log[v0]), 64'(vecs[i].vld0));
            check($sformatf("v%0d_last_addr", i), 64'(addr_log[addr_log.size()-1]), 64'(vecs[i].last_addr));
            check($sformatf("v%0d_done_n", i),    64'(done_cnt - d0), 64'd1);
            @(negedge clk);
            check($sformatf("v%0d_idle_busy", i), 64'(bus.busy), 64'd0);
        end
        check("all_ch_data", 64'(bus.ch_data), 64'h103_102_101_100);

        // ---- burst detail: address order and capture order ----
        run_req(1'b1, "burst");
        check("burst_addr_n", 64'(addr_log.size() - a0), 64'd5);
        check("burst_addr0", 64'(addr_log[a0+0]), 64'd0);
        check("burst_addr1", 64'(addr_log[a0+1]), 64'd4);
        check("burst_addr2", 64'(addr_log[a0+2]), 64'd5);
        check("burst_addr3", 64'(addr_log[a0+3]), 64'd6);
        check("burst_addr4", 64'(addr_log[a0+4]), 64'd0);
        check("burst_vld0", 64'(vld_log[v0+0]), 64'h1);
        check("burst_vld1", 64'(vld_log[v0+1]), 64'h2);
        check("burst_vld2", 64'(vld_log[v0+2]), 64'h4);
        check("burst_vld3", 64'(vld_log[v0+3]), 64'h8);
        check("burst_done_n", 64'(done_cnt - d0), 64'd1);

        // rr stood at 2 before this burst
        run_req(1'b0, "after_burst");
        check("after_burst_vld", 64'(vld_log[v0]), 64'h4);
        check("after_burst_addr", 64'(addr_log[addr_log.size()-1]), 64'd5);

        // ---- nxt held through a whole burst ----
        mark();
        @(negedge clk);
        bus.nxt   = 1'b1;
        bus.burst = 1'b1;
        wait_sweep("hold");
        check("hold_frames", 64'(frames - f0), 64'd5);
        check("hold_vld_n",  64'(vld_log.size() - v0), 64'd4);
        check("hold_done_n", 64'(done_cnt - d0), 64'd1);
        @(negedge clk);
        bus.nxt   = 1'b0;
        bus.burst = 1'b0;
        check("hold_restart_busy", 64'(bus.busy), 64'd1);
        mark();
        wait_sweep("hold2");
        check("hold2_frames", 64'(frames - f0), 64'd5);
        check("hold2_done_n", 64'(done_cnt - d0), 64'd1);

        // ---- reset in the middle of the READ frame ----
        mark();
        pulse_nxt(1'b0);
        begin
            int n = 0;
            while (frames == f0 && n < BUDGET) begin
                @(negedge clk);
                n++;
            end
        end
        check("midrst_first_frame", 64'(frames - f0), 64'd1);
        repeat (200) @(negedge clk);
        check("midrst_in_frame", 64'(SS_n), 64'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_ss_n",    64'(SS_n), 64'd1);
        check("midrst_busy",    64'(bus.busy), 64'd0);
        check("midrst_ch_data", 64'(bus.ch_data), 64'd0);
        check("midrst_ch_vld",  64'(bus.ch_vld), 64'd0);
        check("midrst_done",    64'(bus.sweep_done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_req(1'b0, "post_rst");
        check("post_rst_vld_n", 64'(vld_log.size() - v0), 64'd1);
        check("post_rst_vld",   64'(vld_log[v0]), 64'h1);
        check("post_rst_data",  64'(bus.ch_data), 64'h000_000_000_100);
        check("post_rst_done_n", 64'(done_cnt - d0), 64'd1);

`ifdef A2D_AVG_EN
        // ---- IIR: ch0 seeded at 12'h100, now fed 12'h200 ----
        ch0_val = 12'h200;
        run_req(1'b1, "avg1");
        check("avg1_ch0", 64'(bus.ch_data[11:0]), 64'h140);
        run_req(1'b1, "avg2");
        check("avg2_ch0", 64'(bus.ch_data[11:0]), 64'h170);
        check("avg2_ch3", 64'(bus.ch_data[47:36]), 64'h103);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
